pipe_chain: RTL and testbench
=============================

PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 Parameter STAGES, default 5, number of pipeline registers; legal range 2..8.
REQ-002 Parameter WIDTH, default 32, payload bits per stage.
REQ-003 Parameter CNT_W, default 32, width of each statistics counter.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  payload offered to stage 0.
REQ-007 Port in_data  input  WIDTH  payload offered to stage 0.
REQ-008 Port in_ready  output  1  stage 0 accepts this cycle.
REQ-009 Port stall_req  input  STAGES  bit i: stage i cannot advance.
REQ-010 Port flush  input  STAGES  bit i: kill stage i content.
REQ-011 Port cnt_clr  input  1  zero all counters.
REQ-012 Port stage_valid  output  STAGES  valid bit of each stage register.
REQ-013 Port stage_data  output  STAGES*WIDTH  stage i payload at bits [i*WIDTH +: WIDTH].
REQ-014 Port out_valid  output  1  equals stage_valid[STAGES-1].
REQ-015 Port out_data  output  WIDTH  equals payload of stage STAGES-1.
REQ-016 Port stall_cnt, flush_cnt, retire_cnt  output  CNT_W each  statistics counters.

Function
REQ-017 hold[i] SHALL be the OR of stall_req[j] for all j >= i; a stall at stage j freezes stages 0..j.
REQ-018 in_ready SHALL equal !hold[0], combinationally.
REQ-019 Stage 0, when !hold[0]: SHALL load valid=in_valid, data=in_data if in_valid else 0.
REQ-020 Stage i>0, when !hold[i]: SHALL load valid and data of stage i-1.
REQ-021 Stage i>0, when !hold[i] and hold[i-1]: SHALL load a bubble (valid=0, data=0); the held stage i-1 SHALL NOT be duplicated.
REQ-022 Stage i, when hold[i] and !flush[i]: valid and data SHALL be unchanged.
REQ-023 flush[i] SHALL force stage i to valid=0, data=0 next cycle, overriding hold and incoming advance.
REQ-024 Flush of stage i SHALL NOT affect stage i+1 loading from stage i in the same cycle (old content moves on).
REQ-025 Retirement: a cycle with stage_valid[STAGES-1]=1, stall_req[STAGES-1]=0, flush[STAGES-1]=0 SHALL count as one retire.
REQ-026 stall_cnt SHALL increment by 1 each cycle in which stall_req is nonzero.
REQ-027 flush_cnt SHALL increment by popcount(flush & stage_valid) each cycle.
REQ-028 retire_cnt SHALL increment by 1 per retire (REQ-025).
REQ-029 Counters SHALL saturate at all-ones and not wrap.
REQ-030 cnt_clr SHALL zero all counters next cycle; increments in that cycle are discarded.
REQ-031 No combinational path from stall_req/flush to stage_data/out_data; outputs SHALL be registered except in_ready.
REQ-032 Latency with no stalls/flushes: in_data accepted at edge N SHALL appear on out_data after edge N+STAGES-1.

Reset
REQ-033 When reset=1 at a clock edge: all stage_valid=0, all stage_data=0, all counters=0, regardless of other inputs.
REQ-034 in_ready during reset SHALL follow REQ-018 (reset does not gate it).
REQ-035 Reset asserted mid-operation SHALL discard all in-flight payloads; nothing retires on the reset edge.

Verification
REQ-036 Streaming: STAGES=5, feed 0x1..0x8 on consecutive cycles -> 0x1 on out_data 4 cycles after acceptance, then one per cycle; retire_cnt=8.
REQ-037 Stall: stall_req=5'b00100 one cycle with stages full -> stages 0..2 unchanged, stage 3 bubble, in_ready=0 that cycle, stall_cnt=1.
REQ-038 Flush: stage_valid=5'b11111, flush=5'b00011 -> stages 0,1 invalid next cycle, stage 2 holds old stage 1 payload, flush_cnt=2.
REQ-039 Flush+stall: stall_req[1]=1, flush[1]=1 same cycle -> stage 1 cleared, stage 0 held, stage 2 bubble.
REQ-040 Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=4'hF; cnt_clr -> 0 next cycle.
REQ-041 Reset mid-stream with 3 valid stages -> all valid 0 next cycle, retire_cnt=0, counts restart.

Source files
------------

// File: rtl/pipe_chain.sv
// Linear chain of STAGES valid/data registers with per-stage stall and flush,
// plus saturating statistics counters for stalls, flushed entries and retirements.
module pipe_chain #(
  parameter int STAGES = 5,
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall_req,
  input  logic [STAGES-1:0]       flush,
  input  logic                    cnt_clr,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt,
  output logic [CNT_W-1:0]        retire_cnt
);

  localparam int SUM_W = CNT_W + 4;

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] up_valid;
  logic [WIDTH-1:0]  up_data [STAGES];
  logic [STAGES-1:0] up_held;
  logic [3:0]        flush_inc;
  logic              retire;

  // A stall at stage j freezes everything upstream of it as well.
  always_comb begin
    logic acc;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc  = 1'b0;
    hold = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc     = acc | stall_req[i];
      hold[i] = acc;
    end
  end

  assign in_ready = ~hold[0];

  // What each stage would load when it advances: the input port for stage 0,
  // the previous register otherwise, and whether that source is itself frozen.
  always_comb begin
    up_valid   = '0;
    up_held    = '0;
    up_data[0] = in_valid ? in_data : '0;
    up_valid[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      up_valid[i] = valid_q[i-1];
      up_data[i]  = data_q[i-1];
      up_held[i]  = hold[i-1];
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // stage samples its neighbour's pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      // NOTE: payload registers are reset too; downstream logic observes stage_data
      // directly and expects zeros for empty stages.
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush[i]) begin
          valid_q[i] <= 1'b0;
          data_q[i]  <= '0;
        end else if (!hold[i]) begin
          if (up_held[i]) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= '0;
          end else begin
            valid_q[i] <= up_valid[i];
            data_q[i]  <= up_data[i];
          end
        end
      end
    end
  end

  always_comb begin
    stage_data = '0;
    for (int i = 0; i < STAGES; i++) stage_data[i*WIDTH +: WIDTH] = data_q[i];
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];

  always_comb begin
    flush_inc = '0;
    for (int i = 0; i < STAGES; i++) flush_inc = flush_inc + 4'(flush[i] & valid_q[i]);
  end

  assign retire = valid_q[STAGES-1] & ~stall_req[STAGES-1] & ~flush[STAGES-1];

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0]       b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > SUM_W'({CNT_W{1'b1}})) return '1;
    return sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      stall_cnt  <= sat_add(stall_cnt, {3'b000, |stall_req});
      flush_cnt  <= sat_add(flush_cnt, flush_inc);
      retire_cnt <= sat_add(retire_cnt, {3'b000, retire});
    end
  end

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain: a scoreboard checks retired payloads and their
// arrival cycle; stall/flush/reset/saturation scenarios are checked directly.
module tb_pipe_chain;
  localparam int S  = 5;
  localparam int W  = 32;
  localparam int CW = 32;

  logic           clk = 1'b0;
  logic           reset, in_valid, cnt_clr;
  logic [W-1:0]   in_data;
  logic [S-1:0]   stall_req, flush;

  logic           in_ready, out_valid;
  logic [S-1:0]   stage_valid;
  logic [S*W-1:0] stage_data;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  stall_cnt, flush_cnt, retire_cnt;

  logic           sat_in_ready, sat_out_valid;
  logic [S-1:0]   sat_stage_valid;
  logic [S*W-1:0] sat_stage_data;
  logic [W-1:0]   sat_out_data;
  logic [3:0]     sat_stall_cnt, sat_flush_cnt, sat_retire_cnt;

  pipe_chain #(.STAGES(S), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_req(stall_req), .flush(flush), .cnt_clr(cnt_clr),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
  );

  pipe_chain #(.STAGES(S), .WIDTH(W), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(sat_in_ready),
    .stall_req(stall_req), .flush(flush), .cnt_clr(cnt_clr),
    .stage_valid(sat_stage_valid), .stage_data(sat_stage_data),
    .out_valid(sat_out_valid), .out_data(sat_out_data),
    .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt), .retire_cnt(sat_retire_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit sb_en  = 1'b0;

  typedef struct {
    logic [W-1:0] data;
    int           at;
  } exp_t;
  exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [S*W-1:0] pack(input logic [W-1:0] d4, d3, d2, d1, d0);
    return {d4, d3, d2, d1, d0};
  endfunction

  // Monitor: every retirement while enabled must match the next queued payload and cycle.
  always @(negedge clk) begin
    if (sb_en && out_valid && !stall_req[S-1] && !flush[S-1]) begin
      exp_t e;
      if (sbq.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected retire: got %0h, expected nothing", out_data);
      end else begin
        e = sbq.pop_front();
        check("retire data", out_data, e.data);
        check("retire cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hdead_beef;
    stall_req = 5'b00001; flush = '1; cnt_clr = 1'b0;
    step(); step();
    check("reset valid", stage_valid, 0);
    check("reset data", stage_data, 0);
    check("reset stall_cnt", stall_cnt, 0);
    check("reset flush_cnt", flush_cnt, 0);
    check("reset in_ready stalled", in_ready, 0);
    stall_req = '0;
    #1;
    check("reset in_ready free", in_ready, 1);
    reset = 1'b0; in_valid = 1'b0; in_data = '0; flush = '0;

    // Streaming: 0x1..0x8 back to back, each emerges STAGES edges after being driven.
    sb_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = W'(k);
      sbq.push_back('{data: W'(k), at: cyc + S});
      step();
    end
    in_valid = 1'b0; in_data = '0;
    for (int t = 0; t < 20 && sbq.size() > 0; t++) step();
    check("stream drained", sbq.size(), 0);
    step();
    sb_en = 1'b0;
    check("stream retire_cnt", retire_cnt, 8);
    check("stream stall_cnt", stall_cnt, 0);
    check("stream empty", stage_valid, 0);

    // Stall at stage 2 with the chain full.
    cnt_clr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h10 + W'(k);
      step();
      cnt_clr = 1'b0;
    end
    stall_req = 5'b00100; in_data = 32'h15;
    #1;
    check("stall in_ready", in_ready, 0);
    step();
    check("stall valid", stage_valid, 5'b10111);
    check("stall data", stage_data, pack(32'h11, 32'h0, 32'h12, 32'h13, 32'h14));
    check("stall stall_cnt", stall_cnt, 1);
    check("stall sat stall_cnt", sat_stall_cnt, 1);
    check("stall retire_cnt", retire_cnt, 1);
    stall_req = '0;

    // Flush stages 0 and 1 of a full chain; stage 2 still receives old stage 1.
    for (int k = 0; k < 5; k++) begin
      in_data = 32'h20 + W'(k);
      step();
    end
    check("refill valid", stage_valid, 5'b11111);
    check("refill data", stage_data, pack(32'h20, 32'h21, 32'h22, 32'h23, 32'h24));
    in_valid = 1'b0; flush = 5'b00011;
    step();
    flush = '0;
    check("flush valid", stage_valid, 5'b11100);
    check("flush data", stage_data, pack(32'h21, 32'h22, 32'h23, 32'h0, 32'h0));
    check("flush flush_cnt", flush_cnt, 2);

    // Flush and stall stage 1 together.
    in_valid = 1'b1; in_data = 32'h30;
    step();
    in_data = 32'h31;
    step();
    check("pre flush+stall valid", stage_valid, 5'b10011);
    stall_req = 5'b00010; flush = 5'b00010; in_data = 32'h32;
    #1;
    check("flush+stall in_ready", in_ready, 0);
    step();
    stall_req = '0; flush = '0; in_valid = 1'b0;
    check("flush+stall valid", stage_valid, 5'b00001);
    check("flush+stall data", stage_data, pack(32'h0, 32'h0, 32'h0, 32'h0, 32'h31));
    check("flush+stall flush_cnt", flush_cnt, 3);
    check("flush+stall stall_cnt", stall_cnt, 2);

    // Reset with three stages occupied.
    flush = '1;
    step();
    flush = '0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h40 + W'(k);
      step();
    end
    check("pre reset valid", stage_valid, 5'b00111);
    reset = 1'b1; in_data = 32'h43;
    step();
    check("midreset valid", stage_valid, 0);
    check("midreset data", stage_data, 0);
    check("midreset retire_cnt", retire_cnt, 0);
    check("midreset flush_cnt", flush_cnt, 0);
    reset = 1'b0; in_valid = 1'b0; stall_req = 5'b00001;
    step();
    stall_req = '0;
    check("restart stall_cnt", stall_cnt, 1);
    check("restart retire_cnt", retire_cnt, 0);

    // Saturation of a 4-bit counter and clear under an active stall.
    stall_req = 5'b10000;
    for (int k = 0; k < 20; k++) step();
    check("sat stall_cnt 4b", sat_stall_cnt, 4'hF);
    check("nosat stall_cnt 32b", stall_cnt, 21);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr sat stall_cnt", sat_stall_cnt, 0);
    check("clr stall_cnt", stall_cnt, 0);
    step();
    stall_req = '0;
    check("after clr sat stall_cnt", sat_stall_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
